// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - IEEE 1149.1 TAP: 16-state FSM, IR, BYPASS/IDCODE DRs, TDO mux.
// Define JTAG_IDCODE_EN to include the IDCODE data register and opcode.
module jtag_tap_controller #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1BEE_F0D3
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_tdo,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] instr,
  output logic [3:0]          tap_state,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                select_bsr
);

  localparam logic [3:0] TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = '1;
`endif

  logic [3:0]          state, next_state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass;
  logic                is_idcode;
  logic                is_bypass;
  logic                tdo_next;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state <= TLR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:     next_state = tms ? TLR    : RTI;
      RTI:     next_state = tms ? SEL_DR : RTI;
      SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
      SEL_IR:  next_state = tms ? TLR    : CAP_IR;
      CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms ? SEL_DR : RTI;
      CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
      UPD_IR:  next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  always_comb begin
    tap_state  = state;
    capture_dr = (state == CAP_DR);
    shift_dr   = (state == SH_DR);
    update_dr  = (state == UPD_DR);
  end

  assign select_bsr = (instr == OP_EXTEST) || (instr == OP_SAMPLE);
`ifdef JTAG_IDCODE_EN
  assign is_idcode = (instr == OP_IDCODE);
`else
  assign is_idcode = 1'b0;
`endif
  assign is_bypass = !select_bsr && !is_idcode;

  // Any path into TLR reloads the default instruction, so a stuck TMS=1 always recovers it.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr <= '0;
      instr <= RESET_INSTR;
    end else begin
      if (state == CAP_IR)     ir_sr <= IR_WIDTH'(1);
      else if (state == SH_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
      if (next_state == TLR)   instr <= RESET_INSTR;
      else if (state == UPD_IR) instr <= ir_sr;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst)                                bypass <= 1'b0;
    else if (is_bypass && state == CAP_DR)    bypass <= 1'b0;
    else if (is_bypass && state == SH_DR)     bypass <= tdi;
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sr;
  always_ff @(posedge tck or negedge trst) begin
    if (!trst)                                id_sr <= '0;
    else if (is_idcode && state == CAP_DR)    id_sr <= IDCODE_VAL;
    else if (is_idcode && state == SH_DR)     id_sr <= {tdi, id_sr[31:1]};
  end
  always_comb begin
    tdo_next = 1'b0;
    if (state == SH_IR)      tdo_next = ir_sr[0];
    else if (state == SH_DR) tdo_next = is_bypass ? bypass : (is_idcode ? id_sr[0] : bsr_tdo);
  end
`else
  logic unused_idcode;
  assign unused_idcode = IDCODE_VAL[0];
  always_comb begin
    tdo_next = 1'b0;
    if (state == SH_IR)      tdo_next = ir_sr[0];
    else if (state == SH_DR) tdo_next = is_bypass ? bypass : bsr_tdo;
  end
`endif

  // TDO changes on the falling edge so the downstream device samples it stable on the rising edge.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_next;
      tdo_en <= (state == SH_IR) || (state == SH_DR);
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb/tb_jtag_tap_controller.sv - randomized bench for jtag_tap_controller against a table-driven model.
module tb_jtag_tap_controller;
  localparam int IRW = 4;
  localparam logic [31:0] IDV = 32'h1BEE_F0D3;
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_CAPDR = 4'h6, S_SHDR = 4'h2;
  localparam logic [3:0] S_UPDDR = 4'h5, S_CAPIR = 4'hE, S_SHIR = 4'hA, S_UPDIR = 4'hD;
`ifdef JTAG_IDCODE_EN
  localparam int RESET_INSTR = 2;
`else
  localparam int RESET_INSTR = (1 << IRW) - 1;
`endif

  logic tck = 1'b0, trst = 1'b0, tms = 1'b1, tdi = 1'b0, bsr_tdo = 1'b0;
  logic tdo, tdo_en, capture_dr, shift_dr, update_dr, select_bsr;
  logic [IRW-1:0] instr;
  logic [3:0] tap_state;

  jtag_tap_controller #(.IR_WIDTH(IRW), .IDCODE_VAL(IDV)) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .bsr_tdo(bsr_tdo),
    .tdo(tdo), .tdo_en(tdo_en), .instr(instr), .tap_state(tap_state),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .select_bsr(select_bsr)
  );

  always #5 tck = ~tck;

  int checks = 0, failures = 0;
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] m_state;
  int m_ir, m_instr;
  logic m_byp;
  logic [31:0] m_id;
  logic obs_tdo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_tr(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  // 0 = boundary-scan chain, 1 = bypass, 2 = idcode
  function automatic int dr_kind(input int ins);
    if (ins == 0 || ins == 1) return 0;
`ifdef JTAG_IDCODE_EN
    if (ins == 2) return 2;
`endif
    return 1;
  endfunction

  task automatic model_reset();
    m_state = S_TLR; m_ir = 0; m_instr = RESET_INSTR; m_byp = 1'b0; m_id = '0;
  endtask

  task automatic model_pos(input logic t_ms, input logic t_di);
    int k;
    k = dr_kind(m_instr);
    if (m_state == S_CAPIR) m_ir = 1;
    else if (m_state == S_SHIR) m_ir = (m_ir >> 1) | (int'(t_di) << (IRW - 1));
    if (m_state == S_UPDIR) m_instr = m_ir;
    if (m_state == S_CAPDR) begin
      if (k == 1) m_byp = 1'b0;
      if (k == 2) m_id = IDV;
    end else if (m_state == S_SHDR) begin
      if (k == 1) m_byp = t_di;
      if (k == 2) m_id = {t_di, m_id[31:1]};
    end
    m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
    if (m_state == S_TLR) m_instr = RESET_INSTR;
  endtask

  function automatic logic model_tdo(input logic bsr);
    int k;
    k = dr_kind(m_instr);
    if (m_state == S_SHIR) return m_ir[0];
    if (m_state == S_SHDR) return (k == 1) ? m_byp : (k == 2) ? m_id[0] : bsr;
    return 1'b0;
  endfunction

  task automatic check_regs(input string ph);
    chk({ph, "_state"}, 32'(tap_state), 32'(m_state));
    chk({ph, "_instr"}, 32'(instr), 32'(m_instr));
    chk({ph, "_capture_dr"}, 32'(capture_dr), 32'(m_state == S_CAPDR));
    chk({ph, "_shift_dr"}, 32'(shift_dr), 32'(m_state == S_SHDR));
    chk({ph, "_update_dr"}, 32'(update_dr), 32'(m_state == S_UPDDR));
    chk({ph, "_select_bsr"}, 32'(select_bsr), 32'(dr_kind(m_instr) == 0));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic t_ms, input logic t_di);
    tms = t_ms; tdi = t_di; bsr_tdo = 1'($urandom_range(0, 1));
    @(posedge tck);
    model_pos(t_ms, t_di);
    #1;
    check_regs("pos");
    @(negedge tck);
    #1;
    chk("tdo_en", 32'(tdo_en), 32'((m_state == S_SHIR) || (m_state == S_SHDR)));
    chk("tdo", 32'(tdo), 32'(model_tdo(bsr_tdo)));
    obs_tdo = tdo;
  endtask

  task automatic pulse_trst();
    trst = 1'b0;
    #1;
    model_reset();
    check_regs("trst");
    chk("trst_tdo", 32'(tdo), 32'd0);
    chk("trst_tdo_en", 32'(tdo_en), 32'd0);
    trst = 1'b1;
  endtask

  task automatic goto_rti();
    repeat (5) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IRW-1:0] val, output logic [IRW-1:0] cap);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    cap[0] = obs_tdo;
    for (int i = 0; i < IRW; i++) begin
      step(i == IRW - 1, val[i]);
      if (i < IRW - 1) cap[i+1] = obs_tdo;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic dr_scan4(input logic [3:0] din, output logic [3:0] dout);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    dout[0] = obs_tdo;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, din[i]);
      if (i < 3) dout[i+1] = obs_tdo;
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IRW-1:0] cap;
    logic [3:0] dout;
    logic [31:0] din, stream, exp_stream;

    set_tr(4'hF, 4'hC, 4'hF); set_tr(4'hC, 4'hC, 4'h7); set_tr(4'h7, 4'h6, 4'h4);
    set_tr(4'h4, 4'hE, 4'hF); set_tr(4'h6, 4'h2, 4'h1); set_tr(4'h2, 4'h2, 4'h1);
    set_tr(4'h1, 4'h3, 4'h5); set_tr(4'h3, 4'h3, 4'h0); set_tr(4'h0, 4'h2, 4'h5);
    set_tr(4'h5, 4'hC, 4'h7); set_tr(4'hE, 4'hA, 4'h9); set_tr(4'hA, 4'hA, 4'h9);
    set_tr(4'h9, 4'hB, 4'hD); set_tr(4'hB, 4'hB, 4'h8); set_tr(4'h8, 4'hA, 4'hD);
    set_tr(4'hD, 4'hC, 4'h7);
    model_reset();

    @(negedge tck); #1;
    check_regs("reset");
    chk("reset_tdo", 32'(tdo), 32'd0);
    chk("reset_tdo_en", 32'(tdo_en), 32'd0);
    trst = 1'b1;

    // First DR scan after reset: IDCODE stream, or a 1-bit bypass path.
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
`ifdef JTAG_IDCODE_EN
    din = '0;
    exp_stream = IDV;
`else
    din = $urandom;
    exp_stream = {din[30:0], 1'b0};
`endif
    stream[0] = obs_tdo;
    for (int i = 0; i < 31; i++) begin
      step(1'b0, din[i]);
      stream[i+1] = obs_tdo;
    end
    chk("first_dr_stream", stream, exp_stream);

    repeat (5) step(1'b1, 1'b0);
    chk("t1_tlr_state", 32'(tap_state), 32'hF);
    chk("t1_tlr_instr", 32'(instr), 32'(RESET_INSTR));

    step(1'b0, 1'b0);
    load_ir(4'hF, cap);
    chk("ir_capture", 32'(cap), 32'h1);
    chk("ir_load_f", 32'(instr), 32'hF);
    dr_scan4(4'b1101, dout);
    chk("bypass_scan", 32'(dout), 32'b1010);

    load_ir(4'h0, cap);
    chk("extest_sel", 32'(select_bsr), 32'd1);
    dr_scan4(4'($urandom), dout);

    // Abort an IR shift halfway through.
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    pulse_trst();
    chk("t5_state", 32'(tap_state), 32'hF);

    for (int it = 0; it < 25; it++) begin
      goto_rti();
      load_ir(IRW'($urandom_range(0, (1 << IRW) - 1)), cap);
      chk("rand_ir_capture", 32'(cap), 32'h1);
      for (int j = 0; j < 60; j++) begin
        step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 149) == 0) pulse_trst();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
